// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory port arbiter.
// Holds the owner encoding, the wait-counter width and the default video wait limit.
package dmem_arb_pkg;

   localparam int unsigned WAIT_W       = 4;
   localparam int unsigned MAX_WAIT_DEF = 4;

   localparam logic [1:0] OWN_NONE    = 2'd0;
   localparam logic [1:0] OWN_CORE_RD = 2'd1;
   localparam logic [1:0] OWN_VIDEO   = 2'd2;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter between the core MEM stage and the video reader.
// The core has priority; a starved video request is forced through after MAX_WAIT cycles.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   output logic          d_mem_busy,
   input  logic          v_req,
   input  logic [AW-1:0] v_addr,
   output logic          v_gnt,
   output logic          v_rvalid,
   output logic [DW-1:0] v_rdata,
   output logic          m_en,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   force_cnt
);

   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]        owner;
   logic [DW-1:0]     c_rdata_q;
   logic [DW-1:0]     v_rdata_q;
   logic              force_gnt;

   // Grant decision: core first unless video has waited out its limit
   always_comb begin
      c_gnt = 1'b0;
      v_gnt = 1'b0;
      if (!rst) begin
         if (c_req && (wait_cnt < WAIT_LIM)) begin
            c_gnt = 1'b1;
         end else if (v_req) begin
            v_gnt = 1'b1;
         end
      end
   end

   assign force_gnt  = v_gnt && (wait_cnt == WAIT_LIM);
   assign d_mem_busy = c_req && !c_gnt && !rst;

   assign m_en    = c_gnt || v_gnt;
   assign m_we    = c_gnt && c_we;
   assign m_addr  = v_gnt ? v_addr : c_addr;
   assign m_wdata = c_wdata;

   // Read data returns one cycle after the grant to whichever port owned the read
   assign c_rvalid = !rst && (owner == OWN_CORE_RD);
   assign v_rvalid = !rst && (owner == OWN_VIDEO);
   assign c_rdata  = c_rvalid ? m_rdata : c_rdata_q;
   assign v_rdata  = v_rvalid ? m_rdata : v_rdata_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         owner     <= OWN_NONE;
         c_rdata_q <= '0;
         v_rdata_q <= '0;
         stall_cnt <= '0;
         force_cnt <= '0;
      end else begin
         if (!v_req || v_gnt) begin
            wait_cnt <= '0;
         end else if (wait_cnt != WAIT_LIM) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end

         if (c_gnt && !c_we) begin
            owner <= OWN_CORE_RD;
         end else if (v_gnt) begin
            owner <= OWN_VIDEO;
         end else begin
            owner <= OWN_NONE;
         end

         if (c_rvalid) begin
            c_rdata_q <= m_rdata;
         end
         if (v_rvalid) begin
            v_rdata_q <= m_rdata;
         end

         stall_cnt <= stall_cnt + 32'(d_mem_busy);
         force_cnt <= force_cnt + 32'(force_gnt);
      end
   end

endmodule
